// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
//   Decode-to-issue handshake bundle for the alu_issue stage. The decode side
//   offers one instruction together with its register operands and PC+4; the
//   issue stage signals when it can take it.
//
//   Signals
//     in_valid  decode offers instr + operands
//     in_ready  issue stage accepts this cycle (in_valid & in_ready = accept)
//     instr     32-bit MIPS instruction word
//     rs_data   register rs value
//     rt_data   register rt value
//     pc_plus4  PC+4 of instr
//
//   Modports
//     master    decode side (drives the offer, observes in_ready)
//     slave     alu_issue side
// ---------------------------------------------------------------------------
interface alu_issue_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] pc_plus4;

    modport master (
        output in_valid,
        output instr,
        output rs_data,
        output rt_data,
        output pc_plus4,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  instr,
        input  rs_data,
        input  rt_data,
        input  pc_plus4,
        output in_ready
    );
endinterface

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//   Issue/resolve stage in front of the ALU. Decodes a MIPS R2000 instruction
//   into ALU_ctrl/sel, registers the operands into the ALU, then captures the
//   ALU result/zero flag and emits exactly one of: writeback, branch decision,
//   illegal-instruction pulse or overflow trap.
//
//   Optional feature: define ALU_ISSUE_TRAP_EN to trap signed overflow of
//   add/sub/addi (ovf pulse, writeback suppressed). Without it ovf is always 0.
//
//   Ports
//     clk, reset          rising-edge clock, synchronous active-high reset
//     bus                 alu_issue_if.slave decode handshake + operands
//     op_1, data_2        registered rs/rt values to the ALU
//     sign_ext            registered sign/zero-extended imm16 to the ALU
//     sel                 ALU operand mux: 1 = immediate, 0 = data_2
//     ALU_ctrl            ALU operation code
//     res, zero           combinational ALU result and zero flag
//     wb_valid/reg/data   writeback pulse, destination, captured result
//     br_valid/taken/target  branch resolution pulse, condition, target
//     illegal             unsupported opcode/funct pulse
//     ovf                 signed overflow trap pulse
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_issue_if.slave            bus,
    output logic [DATA_W-1:0]     op_1,
    output logic [DATA_W-1:0]     data_2,
    output logic [DATA_W-1:0]     sign_ext,
    output logic                  sel,
    output logic [3:0]            ALU_ctrl,
    input  logic [DATA_W-1:0]     res,
    input  logic                  zero,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  br_valid,
    output logic                  br_taken,
    output logic [DATA_W-1:0]     br_target,
    output logic                  illegal,
    output logic                  ovf
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    typedef enum logic [1:0] {K_WB, K_BEQ, K_BNE, K_ILL} kind_t;
    typedef enum logic [1:0] {T_NONE, T_ADD, T_SUB} trap_t;

    state_t state, state_next;
    logic   accept;

    // Decode results (combinational from the offered instruction)
    logic [5:0]            opcode, funct;
    logic [15:0]           imm;
    logic [3:0]            dec_ctrl;
    logic                  dec_sel;
    logic                  dec_zext;
    logic [REG_ADDR_W-1:0] dec_dest;
    kind_t                 dec_kind;
    trap_t                 dec_trap;
    logic [DATA_W-1:0]     dec_imm;
    logic [DATA_W-1:0]     dec_tgt;

    // Per-instruction state carried from accept into EXEC
    logic [REG_ADDR_W-1:0] dest_p0;
    kind_t                 kind_p0;
    trap_t                 trap_p0;
    logic [DATA_W-1:0]     tgt_p0;
    logic                  trap_hit;

    // rs field is only needed by the register file, which already read it
    logic unused_rs_field;
    assign unused_rs_field = ^bus.instr[25:21];

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign imm    = bus.instr[15:0];

    assign bus.in_ready = (state != S_EXEC);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        dec_ctrl = 4'b0000;
        dec_sel  = 1'b0;
        dec_zext = 1'b0;
        dec_dest = bus.instr[11 +: REG_ADDR_W];
        dec_kind = K_ILL;
        dec_trap = T_NONE;
        case (opcode)
            6'h00: begin
                dec_kind = K_WB;
                case (funct)
                    6'h20: begin dec_ctrl = 4'b0010; dec_trap = T_ADD; end
                    6'h21: dec_ctrl = 4'b0010;
                    6'h22: begin dec_ctrl = 4'b0110; dec_trap = T_SUB; end
                    6'h23: dec_ctrl = 4'b0110;
                    6'h24: dec_ctrl = 4'b0000;
                    6'h25: dec_ctrl = 4'b0001;
                    6'h27: dec_ctrl = 4'b1100;
                    6'h2A: dec_ctrl = 4'b0111;
                    default: dec_kind = K_ILL;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin
                dec_kind = K_WB;
                dec_sel  = 1'b1;
                dec_dest = bus.instr[16 +: REG_ADDR_W];
                case (opcode)
                    6'h08:   begin dec_ctrl = 4'b0010; dec_trap = T_ADD; end
                    6'h09:   dec_ctrl = 4'b0010;
                    6'h0A:   dec_ctrl = 4'b0111;
                    6'h0C:   begin dec_ctrl = 4'b0000; dec_zext = 1'b1; end
                    default: begin dec_ctrl = 4'b0001; dec_zext = 1'b1; end
                endcase
            end
            6'h04: begin dec_ctrl = 4'b0110; dec_kind = K_BEQ; end
            6'h05: begin dec_ctrl = 4'b0110; dec_kind = K_BNE; end
            default: ;
        endcase
    end

    assign dec_imm = dec_zext ? {{(DATA_W-16){1'b0}}, imm}
                              : {{(DATA_W-16){imm[15]}}, imm};
    // Word-offset branch: sign-extended imm16 shifted left by two, wraps mod 2^32
    assign dec_tgt = bus.pc_plus4 + {{(DATA_W-18){imm[15]}}, imm, 2'b00};

`ifdef ALU_ISSUE_TRAP_EN
    function automatic logic signed_ovf(input logic is_sub,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] r);
        logic sa, sb, sr;
        sa = a[DATA_W-1];
        sb = b[DATA_W-1];
        sr = r[DATA_W-1];
        if (is_sub) return (sa != sb) && (sr != sa);
        else        return (sa == sb) && (sr != sa);
    endfunction

    logic [DATA_W-1:0] alu_b;
    assign alu_b    = sel ? sign_ext : data_2;
    assign trap_hit = (trap_p0 != T_NONE) &&
                      signed_ovf(trap_p0 == T_SUB, op_1, alu_b, res);
`else
    logic unused_trap;
    assign unused_trap = ^trap_p0;
    assign trap_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  state_next = accept ? S_EXEC : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Stage p0: operands and decode captured on accept, held until the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            op_1     <= '0;
            data_2   <= '0;
            sign_ext <= '0;
            sel      <= 1'b0;
            ALU_ctrl <= 4'b0000;
            dest_p0  <= '0;
            kind_p0  <= K_ILL;
            trap_p0  <= T_NONE;
            tgt_p0   <= '0;
        end else if (accept) begin
            op_1     <= bus.rs_data;
            data_2   <= bus.rt_data;
            sign_ext <= dec_imm;
            sel      <= dec_sel;
            ALU_ctrl <= dec_ctrl;
            dest_p0  <= dec_dest;
            kind_p0  <= dec_kind;
            trap_p0  <= dec_trap;
            tgt_p0   <= dec_tgt;
        end
    end

    // Stage p1: ALU result sampled at the end of EXEC, visible during RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
            illegal   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            br_valid <= 1'b0;
            illegal  <= 1'b0;
            ovf      <= 1'b0;
            if (state == S_EXEC) begin
                case (kind_p0)
                    K_WB: begin
                        wb_data  <= res;
                        wb_reg   <= dest_p0;
                        // r0 is hardwired zero: never request a write to it
                        wb_valid <= (dest_p0 != '0) && !trap_hit;
                        ovf      <= trap_hit;
                    end
                    K_BEQ, K_BNE: begin
                        br_valid  <= 1'b1;
                        br_taken  <= (kind_p0 == K_BEQ) ? zero : !zero;
                        br_target <= tgt_p0;
                    end
                    default: illegal <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//   Directed bench for alu_issue: a small reference ALU closes the loop on
//   op_1/data_2/sign_ext/sel/ALU_ctrl -> res/zero; each vector carries
//   hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] op_1, data_2, sign_ext, res, wb_data, br_target;
    logic        sel, zero, wb_valid, br_valid, br_taken, illegal, ovf;
    logic [3:0]  ALU_ctrl;
    logic [4:0]  wb_reg;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_if #(.DATA_W(32)) bus ();

    alu_issue #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .op_1      (op_1),
        .data_2    (data_2),
        .sign_ext  (sign_ext),
        .sel       (sel),
        .ALU_ctrl  (ALU_ctrl),
        .res       (res),
        .zero      (zero),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
        .illegal   (illegal),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference ALU
    logic [31:0] alu_b;
    always_comb begin
        alu_b = sel ? sign_ext : data_2;
        case (ALU_ctrl)
            4'b0010: res = op_1 + alu_b;
            4'b0110: res = op_1 - alu_b;
            4'b0000: res = op_1 & alu_b;
            4'b0001: res = op_1 | alu_b;
            4'b1100: res = ~(op_1 | alu_b);
            4'b0111: res = ($signed(op_1) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        zero = (res == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction; returns one cycle after accept (EXEC)
    task automatic send(input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.rs_data  = a;
        bus.rt_data  = b;
        bus.pc_plus4 = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.instr    = 32'd0;
        bus.rs_data  = 32'd0;
        bus.rt_data  = 32'd0;
        bus.pc_plus4 = 32'd0;
        reset        = 1'b1;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_alu_ctrl", ALU_ctrl, 0);
        check("rst_sel", sel, 0);
        check("rst_op_1", op_1, 0);
        check("rst_pulses", {wb_valid, br_valid, illegal, ovf}, 0);
        check("rst_wb_data", wb_data, 0);
        reset = 1'b0;
        step();

        // add r3,r1,r2 : 5 + 7
        send(32'h0022_1820, 32'd5, 32'd7, 32'h0);
        check("add_exec_ready", bus.in_ready, 0);
        check("add_exec_ctrl", ALU_ctrl, 4'b0010);
        check("add_exec_sel", sel, 0);
        check("add_exec_op1", op_1, 5);
        check("add_exec_wbv", wb_valid, 0);
        step();
        check("add_resp_wbv", wb_valid, 1);
        check("add_resp_reg", wb_reg, 3);
        check("add_resp_data", wb_data, 12);
        check("add_resp_other", {br_valid, illegal, ovf}, 0);
        check("add_resp_ready", bus.in_ready, 1);
        step();
        check("add_idle_wbv", wb_valid, 0);
        check("add_idle_hold", wb_data, 12);

        // ori r4,r0,0x8001 (zero-extended)
        send(32'h3404_8001, 32'd0, 32'd0, 32'h0);
        check("ori_sext", sign_ext, 32'h0000_8001);
        check("ori_sel", sel, 1);
        check("ori_ctrl", ALU_ctrl, 4'b0001);
        step();
        check("ori_wbv", wb_valid, 1);
        check("ori_reg", wb_reg, 4);
        check("ori_data", wb_data, 32'h0000_8001);
        step();

        // addi r5,r0,0x8001 (sign-extended)
        send(32'h2005_8001, 32'd0, 32'd0, 32'h0);
        check("addi_sext", sign_ext, 32'hFFFF_8001);
        step();
        check("addi_wbv", wb_valid, 1);
        check("addi_reg", wb_reg, 5);
        check("addi_data", wb_data, 32'hFFFF_8001);
        step();

        // sub r6,r1,r2 : 5 - 7
        send(32'h0022_3022, 32'd5, 32'd7, 32'h0);
        check("sub_ctrl", ALU_ctrl, 4'b0110);
        step();
        check("sub_data", wb_data, 32'hFFFF_FFFE);
        check("sub_wbv", wb_valid, 1);
        step();

        // beq r1,r2,-1 with equal operands
        send(32'h1022_FFFF, 32'd9, 32'd9, 32'h100);
        check("beq_ctrl", ALU_ctrl, 4'b0110);
        step();
        check("beq_brv", br_valid, 1);
        check("beq_taken", br_taken, 1);
        check("beq_target", br_target, 32'h0000_00FC);
        check("beq_wbv", wb_valid, 0);
        step();
        check("beq_idle_brv", br_valid, 0);

        // bne same operands: not taken
        send(32'h1422_FFFF, 32'd9, 32'd9, 32'h100);
        step();
        check("bne_brv", br_valid, 1);
        check("bne_taken", br_taken, 0);
        check("bne_target", br_target, 32'h0000_00FC);
        step();

        // add overflow 0x7FFFFFFF + 1
        send(32'h0022_1820, 32'h7FFF_FFFF, 32'd1, 32'h0);
        step();
`ifdef ALU_ISSUE_TRAP_EN
        check("ovf_pulse", ovf, 1);
        check("ovf_wbv", wb_valid, 0);
`else
        check("ovf_pulse", ovf, 0);
        check("ovf_wbv", wb_valid, 1);
        check("ovf_data", wb_data, 32'h8000_0000);
`endif
        step();

        // addu overflow never traps
        send(32'h0022_1821, 32'h7FFF_FFFF, 32'd1, 32'h0);
        step();
        check("addu_ovf", ovf, 0);
        check("addu_wbv", wb_valid, 1);
        check("addu_data", wb_data, 32'h8000_0000);
        step();

        // Back-to-back: addu r0 then opcode 0x3F, in_valid held high
        bus.in_valid = 1'b1;
        bus.instr    = 32'h0022_0021;
        bus.rs_data  = 32'd1;
        bus.rt_data  = 32'd2;
        check("b2b_ready0", bus.in_ready, 1);
        step();
        check("b2b_ready1", bus.in_ready, 0);
        bus.instr = 32'hFC00_0000;
        step();
        check("b2b_ready2", bus.in_ready, 1);
        check("b2b_r0_wbv", wb_valid, 0);
        check("b2b_r0_ill", illegal, 0);
        check("b2b_r0_reg", wb_reg, 0);
        check("b2b_r0_data", wb_data, 3);
        step();
        check("b2b_ready3", bus.in_ready, 0);
        check("b2b_ill_ctrl", ALU_ctrl, 4'b0000);
        bus.in_valid = 1'b0;
        step();
        check("b2b_ill", illegal, 1);
        check("b2b_ill_wbv", wb_valid, 0);
        check("b2b_ill_brv", br_valid, 0);
        step();
        check("b2b_ill_gone", illegal, 0);

        // Reset while add is in EXEC
        send(32'h0022_1820, 32'd5, 32'd7, 32'h0);
        check("rexec_ready", bus.in_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rexec_idle_ready", bus.in_ready, 1);
        check("rexec_wbv0", wb_valid, 0);
        check("rexec_ctrl", ALU_ctrl, 0);
        step();
        check("rexec_wbv1", wb_valid, 0);
        step();
        check("rexec_wbv2", wb_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
